// File: rtl/booth_seq_ctrl_pkg.sv
// Shared definitions for the radix-2 Booth multiplier controller and its datapath.
// Widths, the controller state type and the state-to-strobe decode live here.
package booth_seq_ctrl_pkg;

  localparam int DW   = 16;
  localparam int DW_2 = 2 * DW;
  localparam int CW   = $clog2(DW) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Returns {dp_load_n, dp_hold} for a given controller state.
  function automatic logic [1:0] ctrl_decode(input state_e st);
    logic [1:0] strobes;
    case (st)
      IDLE:    strobes = 2'b01;
      RUN:     strobes = 2'b10;
      DONE:    strobes = 2'b11;
      default: strobes = 2'b01;
    endcase
    return strobes;
  endfunction

endpackage

// File: rtl/booth_seq_ctrl_if.sv
// Request, datapath-strobe and result bundle between the requester/datapath side
// (master) and the Booth sequencing controller (slave).
interface booth_seq_ctrl_if #(
  parameter int DW = booth_seq_ctrl_pkg::DW
);
  localparam int CW = $clog2(DW) + 1;

  logic            start;
  logic            abort;
  logic [DW-1:0]   multiplier_in;
  logic [2*DW:0]   dp_product;
  logic            dp_load_n;
  logic            dp_hold;
  logic [DW-1:0]   mult_q;
  logic            busy;
  logic            done;
  logic [2*DW-1:0] result;
  logic [CW-1:0]   iter;

  modport master (
    output start, abort, multiplier_in, dp_product,
    input  dp_load_n, dp_hold, mult_q, busy, done, result, iter
  );

  modport slave (
    input  start, abort, multiplier_in, dp_product,
    output dp_load_n, dp_hold, mult_q, busy, done, result, iter
  );

endinterface

// File: rtl/booth_iter_counter.sv
// Clearable, saturating iteration counter; tc flags the last iteration (count == DW-1).
module booth_iter_counter #(
  parameter int DW = 16,
  parameter int CW = $clog2(DW) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  logic [CW-1:0] count_r;

  // Count enabled iterations, holding at DW until cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && (count_r != CW'(DW))) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign tc    = (count_r == CW'(DW - 1));

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequencing controller for the radix-2 Booth multiplier: loads operands, runs DW
// iterations, captures the product and pulses done; abort cancels without a pulse.
module booth_seq_ctrl #(
  parameter int DW = booth_seq_ctrl_pkg::DW
) (
  input logic             clk,
  input logic             reset,
  booth_seq_ctrl_if.slave bus
);
  import booth_seq_ctrl_pkg::*;

  localparam int CW = $clog2(DW) + 1;

  state_e          state_r;
  state_e          state_nxt_s;
  logic            accept_s;
  logic            finish_s;
  logic            cnt_clr_s;
  logic            cnt_en_s;
  logic            cnt_tc_s;
  logic [CW-1:0]   count_s;
  logic            dp_load_n_r;
  logic            dp_hold_r;
  logic [DW-1:0]   mult_q_r;
  logic            busy_r;
  logic            done_r;
  logic [2*DW-1:0] result_r;
  logic            unused_q_1_s;

  booth_iter_counter #(
    .DW (DW),
    .CW (CW)
  ) u_iter_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr_s),
    .en    (cnt_en_s),
    .count (count_s),
    .tc    (cnt_tc_s)
  );

  assign cnt_en_s = (state_r == RUN);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort takes priority over both start and completion.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    finish_s    = 1'b0;
    cnt_clr_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_nxt_s = RUN;
          accept_s    = 1'b1;
          cnt_clr_s   = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_nxt_s = IDLE;
          cnt_clr_s   = 1'b1;
        end else if (cnt_tc_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
        if (bus.abort) begin
          cnt_clr_s = 1'b1;
        end else begin
          finish_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_clr_s   = 1'b1;
      end
    endcase
  end

  // Registered outputs: strobes and busy follow the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dp_load_n_r <= 1'b0;
      dp_hold_r   <= 1'b1;
      mult_q_r    <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      result_r    <= '0;
    end else begin
      {dp_load_n_r, dp_hold_r} <= ctrl_decode(state_nxt_s);
      busy_r <= (state_nxt_s != IDLE);
      done_r <= finish_s;
      if (accept_s) begin
        mult_q_r <= bus.multiplier_in;
      end else begin
        mult_q_r <= mult_q_r;
      end
      if (finish_s) begin
        result_r <= bus.dp_product[2*DW:1];
      end else begin
        result_r <= result_r;
      end
    end
  end

  // Q-1 is only meaningful inside the datapath.
  assign unused_q_1_s = bus.dp_product[0];

  assign bus.dp_load_n = dp_load_n_r;
  assign bus.dp_hold   = dp_hold_r;
  assign bus.mult_q    = mult_q_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.result    = result_r;
  assign bus.iter      = count_s;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Randomized self-checking bench for booth_seq_ctrl with DW=8; includes a behavioural
// Booth datapath and checks products against plain signed multiplication.
module tb_booth_seq_ctrl;

  localparam int DW = 8;
  localparam int CW = $clog2(DW) + 1;

  logic clk;
  logic reset;
  logic [DW-1:0] mcand;

  int n_vec;
  int n_miss;

  logic [2*DW-1:0] exp_result;
  logic [CW-1:0]   exp_iter;

  booth_seq_ctrl_if #(.DW(DW)) bus ();

  booth_seq_ctrl #(.DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural Booth datapath {A, Q, Q-1}; A carries two guard bits.
  logic signed [DW+1:0] a_r;
  logic signed [DW+1:0] sum_s;
  logic signed [DW+1:0] m_ext_s;
  logic [DW-1:0]        q_r;
  logic                 q1_r;

  always_comb begin
    m_ext_s = $signed({{2{bus.mult_q[DW-1]}}, bus.mult_q});
    case ({q_r[0], q1_r})
      2'b01:   sum_s = a_r + m_ext_s;
      2'b10:   sum_s = a_r - m_ext_s;
      default: sum_s = a_r;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r  <= '0;
      q_r  <= '0;
      q1_r <= 1'b0;
    end else if (!bus.dp_load_n) begin
      a_r  <= '0;
      q_r  <= mcand;
      q1_r <= 1'b0;
    end else if (!bus.dp_hold) begin
      a_r  <= sum_s >>> 1;
      q_r  <= {sum_s[0], q_r[DW-1:1]};
      q1_r <= q_r[0];
    end
  end

  assign bus.dp_product = {a_r[DW-1:0], q_r, q1_r};

  function automatic logic [2*DW-1:0] ref_prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[2*DW-1:0];
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_load_n"}, 64'(bus.dp_load_n), 64'd0);
    check_val({tag, "_hold"},   64'(bus.dp_hold),   64'd1);
    check_val({tag, "_mult_q"}, 64'(bus.mult_q),    64'd0);
    check_val({tag, "_busy"},   64'(bus.busy),      64'd0);
    check_val({tag, "_done"},   64'(bus.done),      64'd0);
    check_val({tag, "_result"}, 64'(bus.result),    64'd0);
    check_val({tag, "_iter"},   64'(bus.iter),      64'd0);
  endtask

  // One idle cycle with optional start/abort; nothing may be accepted when st and ab both set.
  task automatic idle_cycle(input logic st, input logic ab);
    bus.start         = st;
    bus.abort         = ab;
    bus.multiplier_in = DW'($urandom);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_val("idle_busy",   64'(bus.busy),      64'd0);
    check_val("idle_done",   64'(bus.done),      64'd0);
    check_val("idle_load_n", 64'(bus.dp_load_n), 64'd0);
    check_val("idle_result", 64'(bus.result),    64'(exp_result));
    check_val("idle_iter",   64'(bus.iter),      64'(exp_iter));
  endtask

  task automatic abort_step();
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    exp_iter  = '0;
    check_val("abort_busy",   64'(bus.busy),   64'd0);
    check_val("abort_done",   64'(bus.done),   64'd0);
    check_val("abort_iter",   64'(bus.iter),   64'd0);
    check_val("abort_result", 64'(bus.result), 64'(exp_result));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_val("abort_nodone", 64'(bus.done), 64'd0);
    end
  endtask

  // kind: 0 none, 1 spurious start (held through DONE), 2 abort, 3 reset; evt_at = edge index k.
  task automatic run_op(input logic [DW-1:0] mc, input logic [DW-1:0] mp,
                        input int evt_at, input int kind);
    logic [2*DW-1:0] prod;
    prod              = ref_prod(mc, mp);
    mcand             = mc;
    bus.multiplier_in = mp;
    bus.start         = 1'b1;
    bus.abort         = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_val("acc_busy",   64'(bus.busy),   64'd1);
    check_val("acc_done",   64'(bus.done),   64'd0);
    check_val("acc_mult_q", 64'(bus.mult_q), 64'(mp));
    check_val("acc_iter",   64'(bus.iter),   64'd0);
    for (int k = 1; k <= DW; k++) begin
      if (evt_at == k && kind == 1) begin
        bus.start         = 1'b1;
        bus.multiplier_in = 8'd9;
      end
      if (evt_at == k && kind == 2) begin
        abort_step();
        return;
      end
      if (evt_at == k && kind == 3) begin
        #3;
        reset = 1'b0;
        #1;
        check_reset_vals("rst_async");
        @(posedge clk); #1;
        check_reset_vals("rst_held");
        reset      = 1'b1;
        exp_result = '0;
        exp_iter   = '0;
        return;
      end
      @(posedge clk); #1;
      check_val("run_iter",   64'(bus.iter),   64'(k));
      check_val("run_busy",   64'(bus.busy),   64'd1);
      check_val("run_done",   64'(bus.done),   64'd0);
      check_val("run_mult_q", 64'(bus.mult_q), 64'(mp));
      check_val("run_hold",   64'(bus.dp_hold), (k == DW) ? 64'd1 : 64'd0);
    end
    if (evt_at == DW + 1 && kind == 2) begin
      abort_step();
      return;
    end
    @(posedge clk); #1;
    bus.start         = 1'b0;
    bus.multiplier_in = mp;
    exp_result        = prod;
    exp_iter          = CW'(DW);
    check_val("fin_done",   64'(bus.done),   64'd1);
    check_val("fin_result", 64'(bus.result), 64'(prod));
    check_val("fin_busy",   64'(bus.busy),   64'd0);
    check_val("fin_iter",   64'(bus.iter),   64'(DW));
    check_val("fin_mult_q", 64'(bus.mult_q), 64'(mp));
  endtask

  initial begin
    n_vec             = 0;
    n_miss            = 0;
    exp_result        = '0;
    exp_iter          = '0;
    reset             = 1'b0;
    mcand             = '0;
    bus.start         = 1'b0;
    bus.abort         = 1'b0;
    bus.multiplier_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");
    reset = 1'b1;

    run_op(8'd3, 8'd5, 0, 0);
    idle_cycle(1'b0, 1'b0);
    run_op(8'hF9, 8'd6, 0, 0);
    run_op(8'h80, 8'h80, 0, 0);
    run_op(8'd127, 8'h80, 0, 0);
    run_op(8'd3, 8'd5, 3, 1);
    idle_cycle(1'b0, 1'b0);
    run_op(8'd3, 8'd5, 5, 2);
    run_op(8'd2, 8'd2, 0, 0);
    idle_cycle(1'b1, 1'b1);
    idle_cycle(1'b0, 1'b1);
    run_op(8'd3, 8'd5, 4, 3);
    run_op(8'd4, 8'hFC, 0, 0);

    for (int n = 0; n < 40; n++) begin
      int gap;
      int ev;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        idle_cycle(1'($urandom_range(0, 3) == 0), 1'b1);
      end
      ev = int'($urandom_range(0, 9));
      if (ev == 0) begin
        run_op(DW'($urandom), DW'($urandom), int'($urandom_range(1, DW + 1)), 2);
      end else if (ev == 1) begin
        run_op(DW'($urandom), DW'($urandom), int'($urandom_range(1, DW)), 1);
      end else begin
        run_op(DW'($urandom), DW'($urandom), 0, 0);
      end
    end
    idle_cycle(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
